// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Multi-cycle multiply/divide unit with architectural HI/LO registers. It sits
//   in EX beside the ALU. An arithmetic op holds busy for a fixed number of
//   cycles and then commits {hi,lo}. MTHI/MTLO write in zero cycles. stall tells
//   the hazard unit to hold an HI/LO consumer while the unit is occupied.
//
//   Optional feature macro: MDU_MADD_EN
//     defined   : op 6 MADD / op 7 MSUB accumulate a signed product into {hi,lo}
//     undefined : ops 6/7 are accepted as no-ops (no busy, no HI/LO change)
//
// Ports
//   clk      in   system clock
//   reset    in   synchronous active-high; clears all state, aborts in-flight op
//   start    in   E-stage request, accepted only while busy=0
//   op       in   3b: 0 MULT 1 MULTU 2 DIV 3 DIVU 4 MTHI 5 MTLO 6 MADD 7 MSUB
//   a, b     in   forwarded rs / rt operands
//   hi_read  in   E-stage instruction depends on HI/LO (hazard query)
//   busy     out  registered, high while an arithmetic op is in flight
//   stall    out  combinational (busy | start) & hi_read
//   hi, lo   out  architectural HI / LO
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_read,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } md_op_e;

  // Operands latched at accept so the forwarded inputs may change while busy.
  typedef struct packed {
    md_op_e           op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } md_req_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_n;
  logic [CW-1:0]    cnt_q,   cnt_n;
  md_req_t          req_q,   req_n;
  logic [WIDTH-1:0] hi_q,    hi_n;
  logic [WIDTH-1:0] lo_q,    lo_n;

  // ---------------------------------------------------------------------------
  // Result datapath: evaluated behaviourally from the latched request and only
  // sampled into HI/LO on the commit edge.
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] ext_a, ext_b;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [2*WIDTH-1:0] hilo, res;
  logic               div_sgn, neg_a, neg_b;
  logic [WIDTH-1:0]   abs_a, abs_b, dvs;
  logic [WIDTH-1:0]   uq, ur, q, r;

  always_comb begin : datapath
    // Sign-extended 2W-bit multiply keeps the low 2W bits of the signed product.
    ext_a  = {{WIDTH{req_q.a[WIDTH-1]}}, req_q.a};
    ext_b  = {{WIDTH{req_q.b[WIDTH-1]}}, req_q.b};
    prod_s = ext_a * ext_b;
    prod_u = {{WIDTH{1'b0}}, req_q.a} * {{WIDTH{1'b0}}, req_q.b};
    hilo   = {hi_q, lo_q};

    // Signed divide through magnitudes: quotient truncates toward zero and the
    // remainder follows the dividend. Most-negative / -1 falls out naturally:
    // |MIN| / 1 = 2^(W-1), negated mod 2^W is MIN again, remainder 0.
    div_sgn = (req_q.op == OP_DIV);
    neg_a   = div_sgn & req_q.a[WIDTH-1];
    neg_b   = div_sgn & req_q.b[WIDTH-1];
    abs_a   = neg_a ? -req_q.a : req_q.a;
    abs_b   = neg_b ? -req_q.b : req_q.b;
    // Divisor of zero is replaced by one only to keep the divider defined; the
    // commit below discards the result in that case.
    dvs     = (abs_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : abs_b;
    uq      = abs_a / dvs;
    ur      = abs_a % dvs;
    q       = (neg_a ^ neg_b) ? -uq : uq;
    r       = neg_a ? -ur : ur;

    res = hilo;
    case (req_q.op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV,
      OP_DIVU:  if (req_q.b != '0) res = {r, q};
`ifdef MDU_MADD_EN
      // Accumulator is the HI/LO value present at the commit edge.
      OP_MADD:  res = hilo + prod_s;
      OP_MSUB:  res = hilo - prod_s;
`endif
      default:  res = hilo;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin : fsm
    state_n = state_q;
    cnt_n   = cnt_q;
    req_n   = req_q;
    hi_n    = hi_q;
    lo_n    = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (md_op_e'(op))
            OP_MTHI: hi_n = a;
            OP_MTLO: lo_n = a;
            OP_MULT,
            OP_MULTU
`ifdef MDU_MADD_EN
            , OP_MADD,
            OP_MSUB
`endif
            : begin
              req_n.op = md_op_e'(op);
              req_n.a  = a;
              req_n.b  = b;
              cnt_n    = CW'(MULT_CYCLES);
              state_n  = S_RUN;
            end
            OP_DIV,
            OP_DIVU: begin
              req_n.op = md_op_e'(op);
              req_n.a  = a;
              req_n.b  = b;
              cnt_n    = CW'(DIV_CYCLES);
              state_n  = S_RUN;
            end
            default: ; // MADD/MSUB without the feature: accepted, no effect
          endcase
        end
      end

      S_RUN: begin
        // start is ignored here; the request is simply dropped.
        if (cnt_q == CW'(1)) begin
          state_n      = S_IDLE;
          cnt_n        = '0;
          {hi_n, lo_n} = res;
        end else begin
          cnt_n = cnt_q - CW'(1);
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      req_q   <= req_n;
      hi_q    <= hi_n;
      lo_q    <= lo_n;
    end
  end

  assign busy  = (state_q == S_RUN);
  assign stall = (busy | start) & hi_read;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
